hazard_ctrl_mc: RTL
===================

Name: hazard_ctrl_mc

Overview:
Parametrised successor to the pipeline hazard unit in the 5-stage MIPS datapath (F/D/E/M/W). It has four jobs:
- Generates E-stage and D-stage forwarding selects, and the F/D stall and D/E flush controls.
- Tracks a multicycle unit (MULT/DIV writing HI/LO) with a busy countdown.
- Flushes the D stage on taken branches and jumps.
- Keeps saturating stall and flush performance counters.

Sits beside the datapath. All of its outputs feed the pipeline registers, the forwarding muxes and the PC register enable.

Parameters:
RADDR_W, 5, register-address width; register 0 is hard-wired zero and never forwarded or matched.
MC_LAT, 4, cycles the multicycle unit stays busy after issue (legal range 1..255).
MC_W, $clog2(MC_LAT+1), width of the busy counter.
CNT_W, 16, width of each performance counter.

Ports:
clk  in  1  clock; all state updates on the rising edge.
reset  in  1  synchronous, active-low.
rsD  in  RADDR_W  D-stage source register A.
rtD  in  RADDR_W  D-stage source register B.
branchD  in  1  D instruction is a conditional branch.
jumpD  in  1  D instruction is J/JAL.
pcsrcD  in  1  branch taken (branchD & equalD).
mc_useD  in  1  D instruction reads HI/LO or starts a multicycle op.
rsE  in  RADDR_W  E-stage source register A.
rtE  in  RADDR_W  E-stage source register B.
writeregE  in  RADDR_W  E-stage destination register.
regwriteE  in  1  E-stage register-write enable.
memtoregE  in  1  E-stage instruction is a load.
mc_startE  in  1  multicycle op is in E this cycle.
writeregM  in  RADDR_W  M-stage destination register.
regwriteM  in  1  M-stage register-write enable.
memtoregM  in  1  M-stage instruction is a load.
writeregW  in  RADDR_W  W-stage destination register.
regwriteW  in  1  W-stage register-write enable.
perf_clr  in  1  synchronous clear of the performance counters.
forwardAE  out  2  E source A select: 00 regfile, 01 resultW, 10 aluoutM.
forwardBE  out  2  E source B select, same encoding.
forwardAD  out  1  forward aluoutM to the D comparator, source A.
forwardBD  out  1  forward aluoutM to the D comparator, source B.
stallF  out  1  hold the PC.
stallD  out  1  hold the F/D register.
flushD  out  1  clear the F/D register.
flushE  out  1  clear the D/E register.
mc_busy  out  1  multicycle unit busy.
mc_err  out  1  sticky: mc_startE arrived while busy.
stall_cnt  out  CNT_W  count of stall cycles.
flush_cnt  out  CNT_W  count of flushD cycles.

Behaviour:
Forwarding (combinational):
- Define matchX(r,s) = (r != 0) & (r == writeregS) & regwriteS.
- forwardAE = 10 if matchX(rsE,M); else 01 if matchX(rsE,W); else 00. M has priority over W.
- forwardBE is the same rule applied to rtE.
- forwardAD = matchX(rsD,M); forwardBD = matchX(rtD,M).

Stall conditions:
- lwstall = memtoregE & regwriteE & writeregE != 0 & (writeregE == rsD | writeregE == rtD).
- branchstall = branchD & ((regwriteE & writeregE != 0 & writeregE ∈ {rsD,rtD}) | (memtoregM & writeregM != 0 & writeregM ∈ {rsD,rtD})).
- mcstall = mc_useD & (mc_busy | mc_startE).
- stall = lwstall | branchstall | mcstall.
- stallF = stallD = flushE = stall.

D flush:
- flushD = (pcsrcD | jumpD) & ~stall. Stall has priority; the flush is re-evaluated once the stall clears.

Multicycle tracker:
- mc_cnt resets to 0.
- When mc_startE = 1, mc_cnt loads MC_LAT on the next edge.
- Otherwise, if mc_cnt != 0, it decrements by 1.
- mc_busy = (mc_cnt != 0).
- If mc_startE = 1 while mc_busy = 1: mc_cnt reloads and mc_err sets. mc_err clears only on reset.

Performance counters:
- stall_cnt increments on each edge where stall = 1; flush_cnt on each edge where flushD = 1.
- Both saturate at all-ones; they never wrap.
- perf_clr has priority over increment.

Reset (reset = 0, sampled on the edge):
- mc_cnt, mc_err, stall_cnt and flush_cnt all become 0.
- While reset is low, all combinational outputs are forced inactive: forwards 00/0, stalls and flushes 0.

Latency:
- Forward, stall and flush outputs are same-cycle combinational.
- mc_busy rises one edge after mc_startE.

Decomposition:
- Shared package hazard_pkg holds:
  - forward-select constants FWD_RF = 2'b00, FWD_W = 2'b01, FWD_M = 2'b10;
  - the hard-wired zero-register constant REG_ZERO.
- One sub-module, mc_busy_tracker, owns mc_cnt, mc_busy and mc_err, and takes MC_LAT and MC_W as parameters.
- Forwarding, stall and flush logic and the performance counters stay in the top level.

Test Plan:
1. Forward priority: rsE = 3, writeregM = 3, regwriteM = 1, writeregW = 3, regwriteW = 1 -> forwardAE = 10. Then regwriteM = 0 -> forwardAE = 01. Then rsE = 0 -> forwardAE = 00.
2. Load-use: memtoregE = 1, regwriteE = 1, writeregE = 8, rtD = 8 -> stallF = stallD = flushE = 1 for 1 cycle; stall_cnt goes 0 -> 1.
3. Branch hazard: branchD = 1, rsD = 5, regwriteE = 1, writeregE = 5, pcsrcD = 1 -> stall = 1 and flushD = 0. Next cycle, with E cleared and M holding a non-load to reg 5 -> forwardAD = 1, flushD = 1, flush_cnt = 1.
4. Multicycle: MC_LAT = 4, pulse mc_startE -> mc_busy high for exactly 4 cycles. mc_useD held high -> stall on the mc_startE cycle plus 4 busy cycles (5 total), then released.
5. Error and saturation: mc_startE while busy -> mc_err = 1 and the counter reloads. With CNT_W = 4, hold stall for 20 cycles -> stall_cnt = 15. perf_clr -> 0 while mc_err stays 1.
6. Reset mid-operation: reset = 0 while mc_cnt = 2 and stall_cnt = 7 -> after the edge mc_busy = 0, mc_err = 0, counters = 0, and all outputs are inactive while reset is low.

Source files
------------

// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_pkg
//  Purpose  : Shared constants for the pipeline hazard controller.
//             - Forwarding-mux select encodings.
//             - Index of the hard-wired zero register.
//  Revision : 1.0  initial release
// ============================================================================
package hazard_pkg;

  // Select encoding of the E-stage forwarding muxes
  typedef logic [1:0] fwd_sel_t;

  localparam fwd_sel_t FWD_RF = 2'b00;  // register-file read data
  localparam fwd_sel_t FWD_W  = 2'b01;  // resultW
  localparam fwd_sel_t FWD_M  = 2'b10;  // aluoutM

  // Register 0 reads as zero, so it is never matched or forwarded
  localparam int unsigned REG_ZERO = 0;

endpackage
`default_nettype wire

// File: rtl/mc_busy_tracker.sv
`default_nettype none
// ============================================================================
//  Module   : mc_busy_tracker
//  Purpose  : Tracks the multicycle (MULT/DIV -> HI/LO) unit with a busy
//             countdown.
//             - An issue loads MC_LAT into the counter.
//             - The unit is busy while the counter is non-zero.
//             - An issue that arrives while busy reloads the counter and
//               sets a sticky error flag.
//  Ports    : clk        - clock, rising edge
//             reset      - synchronous, active-low
//             mc_start_i - multicycle op is in E this cycle
//             mc_busy_o  - counter non-zero
//             mc_err_o   - sticky: issue seen while busy
//  Revision : 1.0  initial release
// ============================================================================
module mc_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MC_LAT = 4,
  parameter int MC_W   = $clog2(MC_LAT + 1)
) (
  input  logic clk,
  input  logic reset,
  input  logic mc_start_i,
  output logic mc_busy_o,
  output logic mc_err_o
);

  localparam logic [MC_W-1:0] C_LAT = MC_W'(MC_LAT);
  localparam logic [MC_W-1:0] C_ONE = MC_W'(1);

  logic [MC_W-1:0] mc_cnt_q, mc_cnt_d;
  logic            mc_err_q, mc_err_d;

  assign mc_busy_o = (mc_cnt_q != '0);
  assign mc_err_o  = mc_err_q;

  always_comb begin
    mc_cnt_d = mc_cnt_q;
    mc_err_d = mc_err_q;
    if (mc_start_i) begin
      // A new issue always restarts the countdown, even over a busy unit
      mc_cnt_d = C_LAT;
      mc_err_d = mc_err_q | mc_busy_o;
    end else if (mc_busy_o) begin
      mc_cnt_d = mc_cnt_q - C_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      mc_cnt_q <= '0;
      mc_err_q <= 1'b0;
    end else begin
      mc_cnt_q <= mc_cnt_d;
      mc_err_q <= mc_err_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_ctrl_mc.sv
`default_nettype none
// ============================================================================
//  Module   : hazard_ctrl_mc
//  Purpose  : Hazard unit for the 5-stage F/D/E/M/W datapath.
//             - Forwarding selects for the E and D stages.
//             - Load-use, branch and multicycle stalls.
//             - D flush on taken branch or jump.
//             - Saturating stall and flush performance counters.
//  Ports    : clk, reset (sync, active-low)
//             D stage : rsD, rtD, branchD, jumpD, pcsrcD, mc_useD
//             E stage : rsE, rtE, writeregE, regwriteE, memtoregE, mc_startE
//             M stage : writeregM, regwriteM, memtoregM
//             W stage : writeregW, regwriteW
//             perf_clr           - clear performance counters
//             forwardAE/BE       - E-stage mux selects
//             forwardAD/BD       - D-comparator forward from M
//             stallF/stallD/flushD/flushE - pipeline register controls
//             mc_busy/mc_err     - multicycle unit status
//             stall_cnt/flush_cnt - saturating event counters
//  Revision : 1.0  initial release
// ============================================================================
module hazard_ctrl_mc
  import hazard_pkg::*;
#(
  parameter int RADDR_W = 5,
  parameter int MC_LAT  = 4,
  parameter int MC_W    = $clog2(MC_LAT + 1),
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [RADDR_W-1:0] rsD,
  input  logic [RADDR_W-1:0] rtD,
  input  logic               branchD,
  input  logic               jumpD,
  input  logic               pcsrcD,
  input  logic               mc_useD,
  input  logic [RADDR_W-1:0] rsE,
  input  logic [RADDR_W-1:0] rtE,
  input  logic [RADDR_W-1:0] writeregE,
  input  logic               regwriteE,
  input  logic               memtoregE,
  input  logic               mc_startE,
  input  logic [RADDR_W-1:0] writeregM,
  input  logic               regwriteM,
  input  logic               memtoregM,
  input  logic [RADDR_W-1:0] writeregW,
  input  logic               regwriteW,
  input  logic               perf_clr,
  output logic [1:0]         forwardAE,
  output logic [1:0]         forwardBE,
  output logic               forwardAD,
  output logic               forwardBD,
  output logic               stallF,
  output logic               stallD,
  output logic               flushD,
  output logic               flushE,
  output logic               mc_busy,
  output logic               mc_err,
  output logic [CNT_W-1:0]   stall_cnt,
  output logic [CNT_W-1:0]   flush_cnt
);

  localparam logic [RADDR_W-1:0] C_ZERO_REG = RADDR_W'(REG_ZERO);
  localparam logic [CNT_W-1:0]   C_CNT_ONE  = CNT_W'(1);

  // Source r is produced by a writing stage with destination w
  function automatic logic reg_hit(input logic [RADDR_W-1:0] r,
                                   input logic [RADDR_W-1:0] w,
                                   input logic               we);
    return (r != C_ZERO_REG) && (r == w) && we;
  endfunction

  function automatic fwd_sel_t fwd_sel(input logic [RADDR_W-1:0] r);
    // M holds the younger result, so it wins over W
    if (reg_hit(r, writeregM, regwriteM))      return FWD_M;
    else if (reg_hit(r, writeregW, regwriteW)) return FWD_W;
    else                                       return FWD_RF;
  endfunction

  // --------------------------------------------------------------------------
  // Multicycle tracker
  // --------------------------------------------------------------------------
  mc_busy_tracker #(
    .MC_LAT (MC_LAT),
    .MC_W   (MC_W)
  ) u_mc_busy_tracker (
    .clk        (clk),
    .reset      (reset),
    .mc_start_i (mc_startE),
    .mc_busy_o  (mc_busy),
    .mc_err_o   (mc_err)
  );

  // --------------------------------------------------------------------------
  // Stall / flush decode
  // --------------------------------------------------------------------------
  logic w_lwstall, w_brstall, w_mcstall, w_stall, w_flushD;

  assign w_lwstall = memtoregE & regwriteE & (writeregE != C_ZERO_REG) &
                     ((writeregE == rsD) | (writeregE == rtD));

  // The D comparator cannot see an ALU result still in E, nor load data in M
  assign w_brstall = branchD &
                     ((regwriteE & (writeregE != C_ZERO_REG) &
                       ((writeregE == rsD) | (writeregE == rtD))) |
                      (memtoregM & (writeregM != C_ZERO_REG) &
                       ((writeregM == rsD) | (writeregM == rtD))));

  // The issue cycle itself also stalls: the tracker only goes busy next edge
  assign w_mcstall = mc_useD & (mc_busy | mc_startE);

  assign w_stall   = reset & (w_lwstall | w_brstall | w_mcstall);

  // A stalled redirect is held and re-evaluated once the stall clears
  assign w_flushD  = reset & (pcsrcD | jumpD) & ~w_stall;

  always_comb begin
    forwardAE = FWD_RF;
    forwardBE = FWD_RF;
    forwardAD = 1'b0;
    forwardBD = 1'b0;
    if (reset) begin
      forwardAE = fwd_sel(rsE);
      forwardBE = fwd_sel(rtE);
      forwardAD = reg_hit(rsD, writeregM, regwriteM);
      forwardBD = reg_hit(rtD, writeregM, regwriteM);
    end
  end

  assign stallF = w_stall;
  assign stallD = w_stall;
  assign flushE = w_stall;
  assign flushD = w_flushD;

  // --------------------------------------------------------------------------
  // Saturating performance counters
  // --------------------------------------------------------------------------
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
      flush_cnt_d = '0;
    end else begin
      if (w_stall && !(&stall_cnt_q))  stall_cnt_d = stall_cnt_q + C_CNT_ONE;
      if (w_flushD && !(&flush_cnt_q)) flush_cnt_d = flush_cnt_q + C_CNT_ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  assign stall_cnt = stall_cnt_q;
  assign flush_cnt = flush_cnt_q;

endmodule
`default_nettype wire
